// File: rtl/tick_scheduler_pkg.sv
// tick_scheduler_pkg: state encoding and default dividers for the time base
package tick_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, STEP = 2'd3} state_t;
  localparam int SEC_DIV_DEF  = 100_000_000;
  localparam int SCAN_DIV_DEF = 100_000;
  localparam int SEC_W_DEF    = 27;
  localparam int SCAN_W_DEF   = 17;
endpackage

// File: rtl/tick_scheduler_tick_gen.sv
// tick_gen: modulo-DIV enable counter with a registered one-cycle tick on wrap
module tick_gen #(
  parameter int DIV = 4,
  parameter int W   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [W-1:0] cnt;
  logic wrap;
  assign wrap = cnt == W'(DIV - 1);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= en && wrap;
      if (en) cnt <= wrap ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: run/pause/step sequencer producing seconds and display-scan clock enables
import tick_scheduler_pkg::*;
module tick_scheduler #(
  parameter int SEC_DIV  = SEC_DIV_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int SEC_W    = SEC_W_DEF,
  parameter int SCAN_W   = SCAN_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       step,
  input  logic       clr,
  output logic       tick_sec,
  output logic       tick_scan,
  output logic [1:0] scan_sel,
  output logic [1:0] state,
  output logic       running
);
  state_t st, nxt;
  logic step_q, sec_tick;
  // gating en with pause/clr lets a pause at the terminal count freeze it without ticking
  tick_gen #(.DIV(SEC_DIV), .W(SEC_W)) u_sec (
    .clk(clk), .rst_n(rst_n),
    .en(st == RUN && !pause && !clr),
    .clr(clr || st == IDLE || st == STEP),
    .tick(sec_tick)
  );
  tick_gen #(.DIV(SCAN_DIV), .W(SCAN_W)) u_scan (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .tick(tick_scan)
  );
  always_comb begin
    nxt = st;
    if (clr) nxt = IDLE;
    else if (st == STEP) nxt = PAUSE;
    else if (pause) nxt = (st == RUN) ? PAUSE : st;
    else if (st != RUN) nxt = step ? STEP : start ? RUN : st;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      step_q   <= 1'b0;
      scan_sel <= 2'd0;
    end else begin
      st       <= nxt;
      step_q   <= nxt == STEP;
      scan_sel <= scan_sel + {1'b0, tick_scan};
    end
  end
  assign tick_sec = sec_tick | step_q;
  assign state    = st;
  assign running  = st == RUN;
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed and random pulses checked against a cycle-level behavioural model
module tb_tick_scheduler;
  localparam int SD = 10;
  localparam int CD = 4;
  logic clk = 0, rst_n = 0, start = 0, pause = 0, step = 0, clr = 0;
  logic tick_sec, tick_scan, running;
  logic [1:0] scan_sel, state;
  int total = 0, bad = 0;
  int m_st, m_sec, m_scan, m_sel, m_ts, m_tsc;

  tick_scheduler #(.SEC_DIV(SD), .SCAN_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .step(step), .clr(clr),
    .tick_sec(tick_sec), .tick_scan(tick_scan), .scan_sel(scan_sel), .state(state),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // one clock of the stopwatch as described by its rules: 0=idle 1=run 2=pause 3=step
  task automatic model(input bit r, input bit s, input bit p, input bit t, input bit c);
    int nts;
    if (!r) begin
      m_st = 0; m_sec = 0; m_scan = 0; m_sel = 0; m_ts = 0; m_tsc = 0;
      return;
    end
    m_sel = (m_sel + m_tsc) % 4;
    m_tsc = (m_scan == CD - 1);
    m_scan = (m_scan + 1) % CD;
    nts = 0;
    if (m_st == 3) begin
      m_sec = 0;
      m_st = c ? 0 : 2;
    end else if (c) begin
      m_st = 0; m_sec = 0;
    end else if (m_st == 1) begin
      if (p) m_st = 2;
      else if (m_sec == SD - 1) begin m_sec = 0; nts = 1; end
      else m_sec++;
    end else if (!p) begin
      if (t) begin m_st = 3; nts = 1; end
      else if (s) m_st = 1;
    end
    m_ts = nts;
  endtask

  task automatic cyc(input bit s, input bit p, input bit t, input bit c, input bit r = 1);
    start = s; pause = p; step = t; clr = c; rst_n = r;
    @(posedge clk);
    model(r, s, p, t, c);
    #1;
    start = 0; pause = 0; step = 0; clr = 0; rst_n = 1;
    chk("state", state, m_st);
    chk("tick_sec", tick_sec, m_ts);
    chk("tick_scan", tick_scan, m_tsc);
    chk("scan_sel", scan_sel, m_sel);
    chk("running", running, m_st == 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic run_to(input int c);
    for (int i = 0; i < 4 * SD && m_sec != c; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    idle(12);
    cyc(1, 0, 0, 0);
    idle(35);
    run_to(6);
    cyc(0, 1, 0, 0);
    idle(50);
    cyc(1, 0, 0, 0);
    idle(6);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    idle(3);
    cyc(1, 0, 0, 0);
    idle(4);
    cyc(1, 1, 0, 1);
    idle(12);
    cyc(1, 0, 0, 0);
    run_to(8);
    cyc(0, 0, 0, 0, 0);
    idle(3);
    cyc(1, 0, 0, 0);
    run_to(SD - 1);
    cyc(0, 1, 0, 0);
    idle(5);
    cyc(1, 0, 0, 0);
    idle(3);
    run_to(SD - 1);
    cyc(0, 0, 0, 1);
    idle(12);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(15) == 0, $urandom_range(23) == 0, $urandom_range(23) == 0,
          $urandom_range(63) == 0, $urandom_range(299) != 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
